mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_AW, default 14, word-address width of the shared memory port.
REQ-002 Parameter STARVE_LIM, default 4, consecutive IDLE-cycle losses after which a pending IBUS request wins.
REQ-003 Parameter TMO_LIM, default 64, memory-ack timeout in cycles.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ib_req, ib_addr  in  1, 32  instruction fetch request and byte address, read-only.
REQ-007 ib_ack, ib_rdata  out  1, 32  instruction response pulse and data.
REQ-008 mmu_req, mmu_addr  in  1, 32  page-table-walk read request and byte address.
REQ-009 mmu_ack, mmu_rdata  out  1, 32  MMU response pulse and data.
REQ-010 db_cyc, db_we, db_addr, db_sel, db_wdata  in  1, 1, 32, 4, 32  data-bus request, write enable, byte address, byte lanes, write data.
REQ-011 db_ack, db_err, db_rdata  out  1, 1, 32  data-bus response pulse, timeout error, read data.
REQ-012 mem_req, mem_we, mem_addr, mem_sel, mem_wdata  out  1, 1, MEM_AW, 4, 32  single shared memory port command.
REQ-013 mem_ack, mem_rdata  in  1, 32  memory completion pulse and read data.

Function
REQ-014 Requesters hold req/cyc and payload stable until their ack; the block samples payload only in IDLE.
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding.
REQ-016 IDLE: if any request pending, latch winner and payload, go ISSUE; else stay.
REQ-017 Priority: MMU > DBUS > IBUS, except IBUS wins over DBUS (not MMU) when starve_cnt >= STARVE_LIM.
REQ-018 starve_cnt increments (saturating at STARVE_LIM) each IDLE grant to another owner while ib_req high; clears when IBUS is granted or ib_req low.
REQ-019 ISSUE: mem_req=1 for exactly one cycle with latched command; mem_addr = addr[MEM_AW+1:2]; mem_we=db_we and mem_sel=db_sel for DBUS owner, mem_we=0 and mem_sel=4'hF otherwise; go WAIT.
REQ-020 WAIT: mem_req=0; on mem_ack capture mem_rdata, go RESP; timeout counter counts WAIT cycles.
REQ-021 WAIT timeout: counter reaches TMO_LIM without mem_ack -> go RESP with err flag set, rdata 0.
REQ-022 RESP: owner's ack=1 for exactly one cycle with captured rdata; db_err=1 only for DBUS owner on timeout; IBUS/MMU timeout returns ack with rdata 0; go IDLE.
REQ-023 Acks of non-owners are 0 always; rdata outputs hold last value when ack=0.
REQ-024 DBUS write: db_rdata undefined-free, driven 0 during its ack.
REQ-025 Minimum latency with memory ack in the cycle after mem_req: request seen cycle 0 -> mem_req cycle 1 -> mem_ack cycle 2 -> owner ack cycle 3.
REQ-026 mem_ack outside WAIT is ignored.
REQ-027 Request withdrawn after grant: transaction completes; ack still pulsed.

Reset
REQ-028 rst_n low asynchronously forces IDLE, all acks/err/mem_req/mem_we 0, mem_addr/mem_sel/mem_wdata/rdata 0, starve and timeout counters 0.
REQ-029 Reset mid-transaction abandons it; no ack is issued after release; first grant is one cycle after rst_n rises with a request pending.

Verification
REQ-030 Single IBUS read addr 0x0000_0010, memory returns 0xDEAD_BEEF one cycle after mem_req -> mem_addr=4, ib_ack one cycle at cycle 3, ib_rdata=0xDEAD_BEEF.
REQ-031 MMU, DBUS, IBUS all request same cycle -> grant order MMU, DBUS, IBUS; each ack a single-cycle pulse, no overlap.
REQ-032 DBUS issues back-to-back writes continuously with ib_req held, STARVE_LIM=4 -> IBUS granted after 4th DBUS grant.
REQ-033 DBUS write db_sel=4'b0011, data 0x1234_5678 to 0x100 -> mem_we=1, mem_sel=0011, mem_addr=0x40, db_ack with db_rdata=0.
REQ-034 mem_ack never asserted, TMO_LIM=64 -> db_ack and db_err high together 64 cycles into WAIT, FSM back to IDLE.
REQ-035 rst_n pulsed low during WAIT, then late mem_ack -> no ack on any port, outputs 0, next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between MMU, DBUS and IBUS, one transaction at a time
module mem_port_arbiter #(
  parameter int MEM_AW     = 14,
  parameter int STARVE_LIM = 4,
  parameter int TMO_LIM    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ib_req,
  input  logic [31:0]       ib_addr,
  output logic              ib_ack,
  output logic [31:0]       ib_rdata,
  input  logic              mmu_req,
  input  logic [31:0]       mmu_addr,
  output logic              mmu_ack,
  output logic [31:0]       mmu_rdata,
  input  logic              db_cyc,
  input  logic              db_we,
  input  logic [31:0]       db_addr,
  input  logic [3:0]        db_sel,
  input  logic [31:0]       db_wdata,
  output logic              db_ack,
  output logic              db_err,
  output logic [31:0]       db_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam logic [1:0] OWN_IB = 2'd0, OWN_MMU = 2'd1, OWN_DB = 2'd2;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TMO_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_LIM - 1);
  logic [1:0]    state, owner, win;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          we_q, err_q, any_req;
  logic [31:0]   win_addr, rd_val;
  logic          unused_addr_bits;
  // winner of an IDLE-cycle grant and the data a completing transaction returns
  always_comb begin
    any_req  = ib_req | mmu_req | db_cyc;
    win      = mmu_req ? OWN_MMU : (ib_req && starve_cnt >= STARVE_MAX) ? OWN_IB : db_cyc ? OWN_DB : OWN_IB;
    win_addr = (win == OWN_MMU) ? mmu_addr : (win == OWN_DB) ? db_addr : ib_addr;
    rd_val   = (mem_ack && !we_q) ? mem_rdata : 32'd0;
  end
  assign unused_addr_bits = ^{win_addr[31:MEM_AW+2], win_addr[1:0]};
  assign mem_req = (state == ISSUE);
  assign mem_we  = mem_req & we_q;
  assign ib_ack  = (state == RESP) && (owner == OWN_IB);
  assign mmu_ack = (state == RESP) && (owner == OWN_MMU);
  assign db_ack  = (state == RESP) && (owner == OWN_DB);
  assign db_err  = db_ack & err_q;
  // transaction sequencing, command latch and per-port response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IB;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
      mem_addr  <= '0;
      mem_sel   <= '0;
      mem_wdata <= '0;
      ib_rdata  <= '0;
      mmu_rdata <= '0;
      db_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state     <= ISSUE;
          owner     <= win;
          we_q      <= (win == OWN_DB) && db_we;
          mem_addr  <= win_addr[MEM_AW+1:2];
          mem_sel   <= (win == OWN_DB) ? db_sel : 4'hF;
          mem_wdata <= (win == OWN_DB) ? db_wdata : 32'd0;
        end
        ISSUE: begin
          state   <= WAIT;
          tmo_cnt <= '0;
          err_q   <= 1'b0;
        end
        WAIT: if (mem_ack || tmo_cnt == TMO_END) begin
          state <= RESP;
          err_q <= !mem_ack;
          if (owner == OWN_IB) ib_rdata <= rd_val;
          if (owner == OWN_MMU) mmu_rdata <= rd_val;
          if (owner == OWN_DB) db_rdata <= rd_val;
        end else tmo_cnt <= tmo_cnt + TW'(1);
        default: state <= IDLE;
      endcase
    end
  end
  // count IDLE grants that bypass a waiting IBUS request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else if (!ib_req) starve_cnt <= '0;
    else if (state == IDLE && any_req)
      starve_cnt <= (win == OWN_IB) ? '0 : (starve_cnt < STARVE_MAX) ? starve_cnt + SW'(1) : starve_cnt;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory checked against a transaction-level model
module tb_mem_port_arbiter;
  localparam int MEM_AW = 14, STARVE_LIM = 4, TMO_LIM = 64;
  logic clk = 0, rst_n = 0;
  logic ib_req = 0, mmu_req = 0, db_cyc = 0, db_we = 0, mem_ack = 0;
  logic [31:0] ib_addr = 0, mmu_addr = 0, db_addr = 0, db_wdata = 0, mem_rdata = 0;
  logic [3:0] db_sel = 0;
  logic ib_ack, mmu_ack, db_ack, db_err, mem_req, mem_we;
  logic [31:0] ib_rdata, mmu_rdata, db_rdata, mem_wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0] mem_sel;

  mem_port_arbiter #(.MEM_AW(MEM_AW), .STARVE_LIM(STARVE_LIM), .TMO_LIM(TMO_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ib_req(ib_req), .ib_addr(ib_addr), .ib_ack(ib_ack), .ib_rdata(ib_rdata),
    .mmu_req(mmu_req), .mmu_addr(mmu_addr), .mmu_ack(mmu_ack), .mmu_rdata(mmu_rdata),
    .db_cyc(db_cyc), .db_we(db_we), .db_addr(db_addr), .db_sel(db_sel), .db_wdata(db_wdata),
    .db_ack(db_ack), .db_err(db_err), .db_rdata(db_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, owner = 0, issue_cyc = -1, ack_cyc = -1, ack_at = -1, free_at = 0, starve = 0;
  bit busy = 0, m_we = 0, m_err = 0, force_tmo = 0, chk_starve = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0, ack_data = 0, force_data = 0;
  logic [3:0] m_sel = 0;
  logic [31:0] last_rd [3];
  bit outst [3], req_line [3];
  int p_req [3] = '{0, 0, 0};
  int withdraw_pct = 0, tmo_pct = 0, spur_pct = 0, force_delay = 0, db_cnt = 0, t_issue = 0;
  int glog [$];
  int exp_order [3] = '{1, 2, 0};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {ib_ack, mmu_ack, db_ack, db_err, mem_req, mem_we, mem_addr, mem_sel}, 0);
    check({tag, "_data"}, {mem_wdata, ib_rdata, mmu_rdata, db_rdata}, 0);
  endtask

  task automatic model_reset();
    busy = 0; starve = 0; free_at = 0; ack_at = -1; ack_cyc = -1; issue_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 0; outst[i] = 0; req_line[i] = 0;
    end
    ib_req = 0; mmu_req = 0; db_cyc = 0; mem_ack = 0;
  endtask

  task automatic step();
    logic [2:0] exp_acks;
    bit at_issue, at_resp, spur_ok;
    bit granted = 0;
    int w = 0;
    int d;
    @(negedge clk);
    cyc++;
    at_issue = busy && cyc == issue_cyc;
    at_resp = busy && cyc == ack_cyc;
    exp_acks = at_resp ? 3'(1 << owner) : 3'b000;
    check("acks", {db_ack, mmu_ack, ib_ack}, exp_acks);
    check("mem_req", mem_req, at_issue);
    check("mem_we", mem_we, at_issue && m_we);
    if (at_issue) begin
      check("mem_addr", mem_addr, (m_addr >> 2) & ((32'd1 << MEM_AW) - 1));
      check("mem_sel", mem_sel, m_sel);
      if (owner == 2) check("mem_wdata", mem_wdata, m_wdata);
      if (force_tmo || (force_delay == 0 && $urandom_range(0, 99) < tmo_pct)) begin
        ack_at = -1; ack_cyc = cyc + 1 + TMO_LIM; m_data = 0; m_err = 1;
      end else begin
        d = (force_delay != 0) ? force_delay : $urandom_range(1, 3);
        ack_at = cyc + d; ack_cyc = ack_at + 1;
        ack_data = (force_delay != 0) ? force_data : $urandom;
        m_data = m_we ? 32'd0 : ack_data; m_err = 0;
      end
    end
    check("db_err", db_err, at_resp && owner == 2 && m_err);
    if (at_resp) begin
      last_rd[owner] = m_data; busy = 0; free_at = cyc + 1; outst[owner] = 0; req_line[owner] = 0;
    end
    check("rdata", {ib_rdata, mmu_rdata, db_rdata}, {last_rd[0], last_rd[1], last_rd[2]});
    spur_ok = !busy || cyc <= issue_cyc;
    if (busy && cyc == ack_at) begin
      mem_ack = 1; mem_rdata = ack_data;
    end else begin
      mem_ack = spur_ok && $urandom_range(0, 99) < spur_pct; mem_rdata = $urandom;
    end
    for (int i = 0; i < 3; i++) begin
      if (!outst[i] && $urandom_range(0, 99) < p_req[i]) begin
        outst[i] = 1; req_line[i] = 1;
        case (i)
          0: ib_addr = $urandom & 32'hFFFF_FFFC;
          1: mmu_addr = $urandom & 32'hFFFF_FFFC;
          default: begin
            db_addr = $urandom & 32'hFFFF_FFFC; db_we = 1'($urandom_range(0, 1));
            db_sel = 4'($urandom); db_wdata = $urandom;
          end
        endcase
      end else if (busy && owner == i && req_line[i] && $urandom_range(0, 99) < withdraw_pct) req_line[i] = 0;
    end
    ib_req = req_line[0]; mmu_req = req_line[1]; db_cyc = req_line[2];
    if (!busy && cyc >= free_at && (ib_req || mmu_req || db_cyc)) begin
      w = mmu_req ? 1 : (ib_req && starve >= STARVE_LIM) ? 0 : db_cyc ? 2 : 0;
      busy = 1; owner = w; granted = 1; issue_cyc = cyc + 1; ack_cyc = -1; ack_at = -1;
      glog.push_back(w);
      m_addr = (w == 0) ? ib_addr : (w == 1) ? mmu_addr : db_addr;
      m_we = (w == 2) && db_we; m_sel = (w == 2) ? db_sel : 4'hF; m_wdata = db_wdata;
      if (chk_starve && w == 2) db_cnt++;
      if (chk_starve && w == 0) begin
        check("starve_wait", db_cnt, STARVE_LIM);
        db_cnt = 0;
      end
    end
    starve = !ib_req ? 0 : !granted ? starve : (w == 0) ? 0 : (starve < STARVE_LIM) ? starve + 1 : starve;
  endtask

  task automatic drain();
    int n = 0;
    p_req = '{0, 0, 0}; withdraw_pct = 0;
    while (n < 400 && (busy || outst[0] || outst[1] || outst[2])) begin
      step(); n++;
    end
    check("drain", {busy, outst[0], outst[1], outst[2]}, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    ib_addr = 32'h10; outst[0] = 1; req_line[0] = 1; force_delay = 1; force_data = 32'hDEAD_BEEF;
    step(); step();
    check("ib_mem_req", mem_req, 1);
    check("ib_mem_addr", mem_addr, 4);
    step(); step();
    check("ib_ack_c3", ib_ack, 1);
    check("ib_rdata_c3", ib_rdata, 32'hDEAD_BEEF);
    step();
    check("ib_ack_once", ib_ack, 0);
    force_delay = 0;
    glog.delete();
    ib_addr = 32'h40; mmu_addr = 32'h80; db_addr = 32'hC0; db_we = 0; db_sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      outst[i] = 1; req_line[i] = 1;
    end
    drain();
    check("order_n", glog.size(), 3);
    foreach (exp_order[i]) if (i < glog.size()) check("order", glog[i], exp_order[i]);
    db_addr = 32'h100; db_we = 1; db_sel = 4'b0011; db_wdata = 32'h1234_5678;
    outst[2] = 1; req_line[2] = 1; force_delay = 1; force_data = 32'hCAFE_F00D;
    step(); step();
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_sel", mem_sel, 4'b0011);
    check("wr_mem_addr", mem_addr, 14'h40);
    check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    step(); step();
    check("wr_db_ack", db_ack, 1);
    check("wr_db_rdata", db_rdata, 0);
    force_delay = 0;
    drain();
    db_addr = 32'h2000; db_we = 0; outst[2] = 1; req_line[2] = 1; force_tmo = 1;
    step(); step();
    t_issue = cyc;
    for (int n = 0; n < 200 && !db_ack; n++) step();
    check("tmo_latency", cyc - t_issue, 1 + TMO_LIM);
    check("tmo_err", db_err, 1);
    check("tmo_rdata", db_rdata, 0);
    step();
    check("tmo_idle", {ib_ack, mmu_ack, db_ack, db_err, mem_req}, 0);
    force_tmo = 0;
    p_req = '{30, 15, 30}; withdraw_pct = 10; tmo_pct = 3; spur_pct = 10;
    repeat (1500) step();
    drain();
    p_req = '{100, 0, 100}; tmo_pct = 0; chk_starve = 1; db_cnt = 0;
    repeat (300) step();
    chk_starve = 0;
    drain();
    db_addr = 32'h300; db_we = 0; outst[2] = 1; req_line[2] = 1; force_tmo = 1;
    repeat (4) step();
    #2 rst_n = 0;
    #1 check_zero("mid_rst");
    model_reset();
    force_tmo = 0;
    @(negedge clk);
    rst_n = 1;
    spur_pct = 100;
    repeat (4) step();
    check_zero("post_rst");
    p_req = '{30, 15, 30}; withdraw_pct = 10; tmo_pct = 2; spur_pct = 10;
    repeat (800) step();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
